// File: rtl/vec_sq_engine.sv
// Vector engine: loads n elements into an X buffer, computes A*x*x or A*x
// through a 2-stage pipeline into a Y buffer, then streams Y out.
module vec_sq_engine #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int COEF_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   n,
  input  logic [COEF_W-1:0] coef_a,
  input  logic              mode,
  input  logic [DATA_W-1:0] x_data,
  input  logic              x_valid,
  output logic              x_ready,
  output logic [DATA_W-1:0] y_data,
  output logic              y_valid,
  input  logic              y_ready,
  output logic              busy,
  output logic              getx_done,
  output logic              comp_done,
  output logic              sndy_done,
  output logic              err
);

  localparam int              DEPTH   = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_N = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE_N   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] ZERO_N  = {(ADDR_W+1){1'b0}};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_GETX = 3'd1,
    S_COMP = 3'd2,
    S_SNDY = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W:0]     n_q, n_d;
  logic [COEF_W-1:0]   coef_q, coef_d;
  logic                mode_q, mode_d;
  logic [ADDR_W:0]     idx_q, idx_d;
  logic [ADDR_W:0]     wr_q, wr_d;
  logic                s1_v_q, s1_v_d;
  logic [DATA_W-1:0]   s1_x_q, s1_x_d;
  logic [ADDR_W-1:0]   s1_i_q, s1_i_d;
  logic                x_ready_q, x_ready_d;
  logic                y_valid_q, y_valid_d;
  logic [DATA_W-1:0]   y_data_q, y_data_d;
  logic                busy_q, busy_d;
  logic                getx_done_q, getx_done_d;
  logic                comp_done_q, comp_done_d;
  logic                sndy_done_q, sndy_done_d;
  logic                err_q, err_d;

  logic                x_we_s, y_we_s, y_acc_s;
  logic [DATA_W-1:0]   a_ext_s, ax_s, prod_s;

  logic [DATA_W-1:0]   mem_x [DEPTH];
  logic [DATA_W-1:0]   mem_y [DEPTH];

  // Product truncated to DATA_W bits; low bits of a wider product are identical.
  always_comb begin
    a_ext_s = {{(DATA_W-COEF_W){1'b0}}, coef_q};
    ax_s    = a_ext_s * s1_x_q;
    if (mode_q) begin
      prod_s = ax_s;
    end else begin
      prod_s = ax_s * s1_x_q;
    end
  end

  // Next-state, counter and output logic
  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    coef_d      = coef_q;
    mode_d      = mode_q;
    idx_d       = idx_q;
    wr_d        = wr_q;
    s1_v_d      = 1'b0;
    s1_x_d      = s1_x_q;
    s1_i_d      = s1_i_q;
    y_valid_d   = y_valid_q;
    y_data_d    = y_data_q;
    getx_done_d = 1'b0;
    comp_done_d = 1'b0;
    sndy_done_d = 1'b0;
    err_d       = err_q;
    x_we_s      = 1'b0;
    y_we_s      = 1'b0;
    y_acc_s     = y_valid_q & y_ready;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          n_d    = n;
          coef_d = coef_a;
          mode_d = mode;
          err_d  = 1'b0;
          idx_d  = ZERO_N;
          wr_d   = ZERO_N;
          if (n == ZERO_N) begin
            state_d = S_DONE;
          end else if (n > DEPTH_N) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_GETX;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GETX: begin
        if (x_valid && x_ready_q) begin
          x_we_s = 1'b1;
          idx_d  = idx_q + ONE_N;
          if ((idx_q + ONE_N) == n_q) begin
            getx_done_d = 1'b1;
            state_d     = S_COMP;
            idx_d       = ZERO_N;
          end else begin
            state_d = S_GETX;
          end
        end else begin
          state_d = S_GETX;
        end
      end
      S_COMP: begin
        if (idx_q < n_q) begin
          s1_v_d = 1'b1;
          s1_x_d = mem_x[idx_q[ADDR_W-1:0]];
          s1_i_d = idx_q[ADDR_W-1:0];
          idx_d  = idx_q + ONE_N;
        end else begin
          s1_v_d = 1'b0;
        end
        if (s1_v_q) begin
          y_we_s = 1'b1;
          if ({1'b0, s1_i_q} == (n_q - ONE_N)) begin
            comp_done_d = 1'b1;
            state_d     = S_SNDY;
            idx_d       = ZERO_N;
            wr_d        = ZERO_N;
          end else begin
            state_d = S_COMP;
          end
        end else begin
          state_d = S_COMP;
        end
      end
      S_SNDY: begin
        if (y_acc_s) begin
          wr_d = wr_q + ONE_N;
        end else begin
          wr_d = wr_q;
        end
        // Next element is fetched whenever the output register is empty or draining.
        if (y_acc_s && ((wr_q + ONE_N) == n_q)) begin
          sndy_done_d = 1'b1;
          y_valid_d   = 1'b0;
          state_d     = S_DONE;
        end else if ((!y_valid_q || y_acc_s) && (idx_q < n_q)) begin
          y_data_d  = mem_y[idx_q[ADDR_W-1:0]];
          y_valid_d = 1'b1;
          idx_d     = idx_q + ONE_N;
        end else if (y_acc_s) begin
          y_valid_d = 1'b0;
        end else begin
          y_valid_d = y_valid_q;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d   = S_IDLE;
        y_valid_d = 1'b0;
      end
    endcase

    busy_d    = (state_d != S_IDLE);
    x_ready_d = (state_d == S_GETX) && (idx_d < n_d);
  end

  // Control and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      n_q         <= ZERO_N;
      coef_q      <= {COEF_W{1'b0}};
      mode_q      <= 1'b0;
      idx_q       <= ZERO_N;
      wr_q        <= ZERO_N;
      s1_v_q      <= 1'b0;
      s1_x_q      <= {DATA_W{1'b0}};
      s1_i_q      <= {ADDR_W{1'b0}};
      x_ready_q   <= 1'b0;
      y_valid_q   <= 1'b0;
      y_data_q    <= {DATA_W{1'b0}};
      busy_q      <= 1'b0;
      getx_done_q <= 1'b0;
      comp_done_q <= 1'b0;
      sndy_done_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      coef_q      <= coef_d;
      mode_q      <= mode_d;
      idx_q       <= idx_d;
      wr_q        <= wr_d;
      s1_v_q      <= s1_v_d;
      s1_x_q      <= s1_x_d;
      s1_i_q      <= s1_i_d;
      x_ready_q   <= x_ready_d;
      y_valid_q   <= y_valid_d;
      y_data_q    <= y_data_d;
      busy_q      <= busy_d;
      getx_done_q <= getx_done_d;
      comp_done_q <= comp_done_d;
      sndy_done_q <= sndy_done_d;
      err_q       <= err_d;
    end
  end

  // X buffer write port
  always_ff @(posedge clk) begin
    if (x_we_s) begin
      mem_x[idx_q[ADDR_W-1:0]] <= x_data;
    end
  end

  // Y buffer write port (pipeline stage 2)
  always_ff @(posedge clk) begin
    if (y_we_s) begin
      mem_y[s1_i_q] <= prod_s;
    end
  end

  assign x_ready   = x_ready_q;
  assign y_data    = y_data_q;
  assign y_valid   = y_valid_q;
  assign busy      = busy_q;
  assign getx_done = getx_done_q;
  assign comp_done = comp_done_q;
  assign sndy_done = sndy_done_q;
  assign err       = err_q;

endmodule

// File: doc/vec_sq_engine.md
Name: vec_sq_engine

Overview:
- Parametrised successor of the single-shot X-load / compute / Y-send unit.
- Accepts a vector of n elements over a valid/ready stream into an internal X buffer.
- Computes y[i] = A*x[i]*x[i] (mode 0) or y[i] = A*x[i] (mode 1) through a 2-stage pipeline into a Y buffer, then streams Y out over valid/ready.
- Re-armable via start (returns to IDLE, no trap state); sits between the memory-mapped register front end and the host driver.

Parameters:
- DATA_W, 32: width of x, y and the internal buffer words.
- ADDR_W, 10: buffer address width; DEPTH = 2**ADDR_W words per buffer.
- COEF_W, 8: width of the coefficient input coef_a.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- start  in  1  1-cycle request to begin a job; sampled only in IDLE.
- n  in  ADDR_W+1  vector length, latched at start.
- coef_a  in  COEF_W  unsigned coefficient A, latched at start.
- mode  in  1  0: A*x*x, 1: A*x; latched at start.
- x_data  in  DATA_W  input element.
- x_valid  in  1  x_data valid.
- x_ready  out  1  engine accepts x_data this cycle.
- y_data  out  DATA_W  output element.
- y_valid  out  1  y_data valid.
- y_ready  in  1  consumer accepts y_data this cycle.
- busy  out  1  high in any state other than IDLE.
- getx_done  out  1  1-cycle pulse when the last X is stored.
- comp_done  out  1  1-cycle pulse when the last Y is written.
- sndy_done  out  1  1-cycle pulse when the last Y is accepted.
- err  out  1  sticky; set when a job is started with n > DEPTH; cleared by the next accepted start.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; all outputs 0; counters 0; buffer contents undefined. Reset mid-job aborts with no partial-completion pulses.
- States: IDLE, GETX, COMP, SNDY, DONE.
- IDLE -> GETX on start=1: latch n, coef_a, mode; clear err.
  - start with n==0: go to DONE directly; no x accepted; no getx/comp/sndy pulses.
  - start with n>DEPTH: set err; go to DONE; buffers untouched.
- GETX:
  - x_ready=1 while the element count is below n.
  - A transfer occurs when x_valid & x_ready: memX[cnt] <= x_data, cnt++.
  - On the n-th transfer, pulse getx_done in the following cycle; x_ready drops to 0 in the same following cycle; state -> COMP.
  - x_valid with x_ready=0 is ignored; no data is lost or duplicated.
- COMP:
  - Stage 1: read memX[i], i = 0..n-1, one per cycle.
  - Stage 2: register the product and write memY[i].
  - Arithmetic: full-precision unsigned product, truncated to the low DATA_W bits (mod 2**DATA_W); no saturation.
  - Last write occurs n+1 cycles after entering COMP; comp_done pulses with that write; state -> SNDY next cycle.
- SNDY:
  - memY is read ahead so y_valid rises no later than 2 cycles after entering SNDY.
  - When y_ready is held high, throughput is 1 element/cycle; elements are output in index order 0..n-1.
  - While y_valid=1 & y_ready=0, y_data is held stable.
  - On the n-th accepted transfer: sndy_done pulses the next cycle, y_valid=0, state -> DONE.
- DONE: one cycle, then -> IDLE; busy drops on entry to IDLE.
- start outside IDLE is ignored.
- y_data keeps its last value after a job; it is only meaningful while y_valid=1.
- x_data and coef_a are unsigned.

Test Plan:
- Reset, DATA_W=32, A=4, mode 0, n=4: stream x = 1,2,3,0xFFFF -> y = 4,16,36,0xFFF80004 (truncated). getx_done, comp_done and sndy_done each pulse exactly once. busy returns to 0.
- Backpressure on x and y, n=8, mode 1, A=3, x=i+1:
  - Toggle x_valid randomly; hold y_ready=0 for 5 cycles mid-stream.
  - Expect y = 3,6,...,24 in order, no duplicates, and y_data stable while stalled.
- Boundary n:
  - n=0 -> busy for one cycle, no x_ready, no y_valid, no done pulses.
  - n=DEPTH -> exactly DEPTH x accepted and DEPTH y emitted.
  - n=DEPTH+1 -> err=1, no transfers.
- Throughput: x_valid and y_ready tied high, n=16 -> GETX lasts 16 accept cycles, COMP lasts ≤ n+2 cycles, y emitted on 16 consecutive cycles.
- Reset mid-job:
  - Assert reset during SNDY after 2 of 6 y sent -> all outputs 0 immediately.
  - Then start again with n=2, x=5,7, A=1, mode 0 -> y=25,49.
- start while busy during GETX is ignored. A second job back-to-back after DONE with different coef_a/mode uses the newly latched values.
